exc_check_responder: RTL and testbench

Callee-side exception checker serving the adder controller's ExcCheck request/acknowledge interface. It captures a 16-bit half-width float word (1 sign, 8 exponent, 7 mantissa bits) when the controller raises ExcCheck_valid. After a programmable classification latency it returns a 3-bit exception code with a single-cycle Exc_Ack. Its code values match the controller's decode: 0 or 3'b111 lets the controller continue; any other value makes it abort to output.

---
 rtl/exc_check_responder.sv | 138 +++++++++++++
 tb/tb_exc_check_responder.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exc_check_responder.sv
// Exception classifier for the adder controller's ExcCheck handshake; EXC_CHECK_STICKY_EN adds sticky flags.
// Ack arrives LATENCY+1 cycles after capture; dropping the request mid-classify aborts silently.
module exc_check_responder #(
  parameter int unsigned LATENCY = 1
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        ExcCheck_valid,
  input  logic [15:0] ExcCheck_Datain,
  output logic [2:0]  Exc_value,
  output logic        Exc_Ack,
  output logic        Busy,
  output logic [2:0]  Debug
`ifdef EXC_CHECK_STICKY_EN
  ,
  input  logic        Sticky_clr,
  output logic [3:0]  Sticky_flags
`endif
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CLASSIFY = 3'd1,
    ACK      = 3'd2,
    RELEASE  = 3'd3
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [14:0] data_q;   // sign bit is never needed for classification
  logic [2:0]  val_q;
  logic        ack_q;
  logic        busy_q;

  logic [7:0]  exp_w;
  logic [6:0]  man_w;
  logic [2:0]  code;
  logic [3:0]  flag;

  assign exp_w = data_q[14:7];
  assign man_w = data_q[6:0];

  always_comb begin
    code = 3'b000;
    flag = 4'b0000;
    if (exp_w == 8'hFF) begin
      if (man_w != 7'd0) begin
        code = 3'b011;
        flag = 4'b1000;
      end else begin
        code = 3'b010;
        flag = 4'b0100;
      end
    end else if (exp_w == 8'h00) begin
      if (man_w == 7'd0) begin
        code = 3'b111;
        flag = 4'b0010;
      end else begin
        flag = 4'b0001;
      end
    end
  end

`ifdef EXC_CHECK_STICKY_EN
  logic [3:0] sticky_q;
  logic [3:0] sticky_d;

  // Clear and set in the same cycle: the bit being set survives.
  always_comb begin
    sticky_d = Sticky_clr ? 4'b0000 : sticky_q;
    if (state_q == ACK) sticky_d = sticky_d | flag;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) sticky_q <= 4'b0000;
    else       sticky_q <= sticky_d;
  end

  assign Sticky_flags = sticky_q;
`endif

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      data_q  <= 15'd0;
      val_q   <= 3'b000;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ExcCheck_valid) begin
            data_q  <= ExcCheck_Datain[14:0];
            cnt_q   <= CNT_INIT;
            state_q <= CLASSIFY;
            busy_q  <= 1'b1;
          end
        end
        CLASSIFY: begin
          // A withdrawn request wins over a counter that has just expired.
          if (!ExcCheck_valid) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (cnt_q == 4'd0) begin
            state_q <= ACK;
            ack_q   <= 1'b1;
            val_q   <= code;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ACK: begin
          state_q <= RELEASE;
        end
        RELEASE: begin
          if (!ExcCheck_valid) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign Exc_value = val_q;
  assign Exc_Ack   = ack_q;
  assign Busy      = busy_q;
  assign Debug     = state_q;

endmodule

// File: tb/tb_exc_check_responder.sv
// Randomised bench for exc_check_responder at LATENCY 1, 3 and 4 against a spec-level reference model.
// Sticky-flag checks are compiled in only when EXC_CHECK_STICKY_EN is defined.
module tb_exc_check_responder;

  localparam int LATS [3] = '{1, 3, 4};

  logic        clk;
  logic        rst_n;
  logic        vld [3];
  logic [15:0] din [3];
  logic [2:0]  val [3];
  logic        ack [3];
  logic        busy [3];
  logic [2:0]  dbg [3];
  logic        clr [3];
  logic [3:0]  flg [3];

  int n_cmp = 0;
  int n_err = 0;

  logic [2:0] last_val [3];
  logic [3:0] sticky_m [3];

  exc_check_responder #(.LATENCY(1)) u_lat1 (
    .CLK(clk), .RSTn(rst_n), .ExcCheck_valid(vld[0]), .ExcCheck_Datain(din[0]),
    .Exc_value(val[0]), .Exc_Ack(ack[0]), .Busy(busy[0]), .Debug(dbg[0])
`ifdef EXC_CHECK_STICKY_EN
    , .Sticky_clr(clr[0]), .Sticky_flags(flg[0])
`endif
  );

  exc_check_responder #(.LATENCY(3)) u_lat3 (
    .CLK(clk), .RSTn(rst_n), .ExcCheck_valid(vld[1]), .ExcCheck_Datain(din[1]),
    .Exc_value(val[1]), .Exc_Ack(ack[1]), .Busy(busy[1]), .Debug(dbg[1])
`ifdef EXC_CHECK_STICKY_EN
    , .Sticky_clr(clr[1]), .Sticky_flags(flg[1])
`endif
  );

  exc_check_responder #(.LATENCY(4)) u_lat4 (
    .CLK(clk), .RSTn(rst_n), .ExcCheck_valid(vld[2]), .ExcCheck_Datain(din[2]),
    .Exc_value(val[2]), .Exc_Ack(ack[2]), .Busy(busy[2]), .Debug(dbg[2])
`ifdef EXC_CHECK_STICKY_EN
    , .Sticky_clr(clr[2]), .Sticky_flags(flg[2])
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int unsigned got, input int unsigned want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic logic [2:0] ref_code(input logic [15:0] w);
    int e, m;
    e = int'(w[14:7]);
    m = int'(w[6:0]);
    if (e == 255 && m != 0) return 3'b011;
    if (e == 255)           return 3'b010;
    if (e == 0 && m == 0)   return 3'b111;
    return 3'b000;
  endfunction

  function automatic logic [3:0] ref_flag(input logic [15:0] w);
    int e, m;
    e = int'(w[14:7]);
    m = int'(w[6:0]);
    if (e == 255 && m != 0) return 4'b1000;
    if (e == 255)           return 4'b0100;
    if (e == 0 && m == 0)   return 4'b0010;
    if (e == 0)             return 4'b0001;
    return 4'b0000;
  endfunction

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    logic [7:0]  e;
    logic [6:0]  m;
    case ($urandom_range(0, 2))
      0:       e = 8'h00;
      1:       e = 8'hFF;
      default: e = 8'($urandom_range(1, 254));
    endcase
    m = ($urandom_range(0, 1) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
    w = {1'($urandom_range(0, 1)), e, m};
    return w;
  endfunction

  task automatic check_sticky(input string tag, input int k);
`ifdef EXC_CHECK_STICKY_EN
    chk(tag, flg[k], sticky_m[k]);
`endif
  endtask

  // Full request: valid held until ack, then for `extra` more cycles.
  task automatic run_req(input int k, input logic [15:0] w, input int extra, input bit clr_at_ack);
    int lat, first, pulses;
    logic [2:0] want;
    lat = LATS[k];
    want = ref_code(w);
    first = 0;
    pulses = 0;
    @(negedge clk);
    vld[k] = 1'b1;
    din[k] = w;
    for (int n = 1; n <= lat + 1; n++) begin
      @(posedge clk); #1;
      if (n == 1) begin
        din[k] = 16'($urandom);
        chk("busy_after_capture", busy[k], 1);
        chk("dbg_classify", dbg[k], 1);
      end
      if (ack[k]) begin
        pulses++;
        if (first == 0) first = n;
      end
    end
    chk("ack_latency", first, lat + 1);
    chk("exc_value", val[k], want);
    chk("dbg_ack", dbg[k], 2);
    last_val[k] = want;
`ifdef EXC_CHECK_STICKY_EN
    if (clr_at_ack) begin
      clr[k] = 1'b1;
      sticky_m[k] = ref_flag(w);
    end else begin
      sticky_m[k] = sticky_m[k] | ref_flag(w);
    end
`else
    if (clr_at_ack) sticky_m[k] = ref_flag(w);
    else            sticky_m[k] = sticky_m[k] | ref_flag(w);
`endif
    for (int i = 0; i < extra; i++) begin
      @(posedge clk); #1;
      clr[k] = 1'b0;
      if (ack[k]) pulses++;
      chk("dbg_release_hold", dbg[k], 3);
    end
    @(negedge clk);
    vld[k] = 1'b0;
    @(posedge clk); #1;
    clr[k] = 1'b0;
    if (ack[k]) pulses++;
    chk("dbg_after_drop", dbg[k], (extra == 0) ? 3 : 0);
    if (extra == 0) begin
      @(posedge clk); #1;
      if (ack[k]) pulses++;
      chk("dbg_idle", dbg[k], 0);
    end
    chk("busy_idle", busy[k], 0);
    chk("ack_pulses", pulses, 1);
    chk("exc_value_hold", val[k], want);
    check_sticky("sticky_after_req", k);
  endtask

  // Request withdrawn two cycles into CLASSIFY; only for LATENCY >= 2.
  task automatic abort_req(input int k, input logic [15:0] w);
    int pulses;
    pulses = 0;
    @(negedge clk);
    vld[k] = 1'b1;
    din[k] = w;
    repeat (2) begin
      @(posedge clk); #1;
      if (ack[k]) pulses++;
    end
    @(negedge clk);
    vld[k] = 1'b0;
    @(posedge clk); #1;
    chk("abort_dbg_idle", dbg[k], 0);
    chk("abort_busy", busy[k], 0);
    repeat (5) begin
      @(posedge clk); #1;
      if (ack[k]) pulses++;
    end
    chk("abort_no_ack", pulses, 0);
    chk("abort_value_kept", val[k], last_val[k]);
    check_sticky("abort_sticky_kept", k);
  endtask

  task automatic clear_pulse(input int k);
`ifdef EXC_CHECK_STICKY_EN
    @(negedge clk);
    clr[k] = 1'b1;
    @(posedge clk); #1;
    clr[k] = 1'b0;
    sticky_m[k] = 4'b0000;
    chk("sticky_cleared", flg[k], 0);
`else
    @(negedge clk);
    sticky_m[k] = 4'b0000;
`endif
  endtask

  task automatic check_all_zero(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk({tag, "_val"}, val[k], 0);
      chk({tag, "_ack"}, ack[k], 0);
      chk({tag, "_busy"}, busy[k], 0);
      chk({tag, "_dbg"}, dbg[k], 0);
      check_sticky({tag, "_sticky"}, k);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      vld[k] = 1'b0;
      din[k] = 16'h0000;
      clr[k] = 1'b0;
      last_val[k] = 3'b000;
      sticky_m[k] = 4'b0000;
`ifndef EXC_CHECK_STICKY_EN
      flg[k] = 4'b0000;
`endif
    end
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    run_req(0, 16'h3F80, 0, 1'b0);
    run_req(0, 16'h7F80, 0, 1'b0);
    run_req(0, 16'h7FC0, 0, 1'b0);
    run_req(0, 16'h8000, 0, 1'b0);
`ifdef EXC_CHECK_STICKY_EN
    chk("sticky_three", flg[0], 4'b1110);
`endif
    clear_pulse(0);
    run_req(1, 16'h0001, 0, 1'b0);
`ifdef EXC_CHECK_STICKY_EN
    chk("sticky_subnormal", flg[1][0], 1);
`endif
    run_req(0, 16'h3F80, 10, 1'b0);
    run_req(2, 16'h7FC0, 10, 1'b0);
    abort_req(2, 16'h7F80);
    run_req(1, 16'h7F80, 0, 1'b1);

    // Asynchronous reset in the middle of CLASSIFY.
    @(negedge clk);
    vld[2] = 1'b1;
    din[2] = 16'h7F80;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      last_val[k] = 3'b000;
      sticky_m[k] = 4'b0000;
    end
    #1;
    check_all_zero("async_reset");
    vld[2] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_req(2, 16'h7F80, 0, 1'b0);

    for (int it = 0; it < 40; it++) begin
      int k;
      k = $urandom_range(0, 2);
      case ($urandom_range(0, 5))
        0: if (k != 0) abort_req(k, rand_word());
           else        run_req(k, rand_word(), 0, 1'b0);
        1: clear_pulse(k);
        2: run_req(k, rand_word(), $urandom_range(1, 3), 1'b1);
        default: run_req(k, rand_word(), $urandom_range(0, 2), 1'b0);
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
